mul_4x4_4x2_host: RTL
=====================

Name: mul_4x4_4x2_host

Overview:
- Initiator/host side of the 4x4-by-4x2 matrix-multiply start/done interface used in the ZF detector datapath.
- Accepts a serial stream of 32-bit words: 16 words of matrix A (row-major), then 8 words of matrix B (row-major).
- Packs them into the flat A/B operand buses, pulses start, waits for done, captures the 256-bit result and streams it out as 8 words.
- Sits between the upstream channel-estimate/word-stream logic and one external multiplier instance.

Parameters:
- DW, 32, element word width (packed complex fixed-point word; treated as opaque here).
- NA, 16, A words per frame.
- NB, 8, B words per frame.
- NR, 8, result words per frame.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  host can accept a word
- in_data  input  DW  input word (A words 0..15, then B words 0..7)
- mul_start  output  1  one-cycle start pulse to the multiplier
- mul_A  output  NA*DW  packed A; word 0 in bits [511:480], word 15 in [31:0]
- mul_B  output  NB*DW  packed B; word 0 in bits [255:224], word 7 in [31:0]
- mul_done  input  1  multiplier done pulse
- mul_result  input  NR*DW  multiplier result; valid in the cycle mul_done=1
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts the output word
- out_data  output  DW  output word; word 0 = result[255:224]
- out_last  output  1  high with the 8th output word
- busy  output  1  high in every state except LOAD
- frame_cnt  output  8  completed frames, wraps 255->0

Behaviour:
- Reset (async, active-high):
  - state=LOAD, word counter=0.
  - All outputs 0, except in_ready=1 after reset deasserts.
  - mul_A, mul_B and the result buffer cleared.
  - Reset mid-operation aborts the frame; partially loaded words are discarded.
- States: LOAD -> START -> WAIT -> SEND -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, word k (k=0..23) is written: k<16 to A slot k, otherwise B slot k-16; counter increments.
  - When word 23 is accepted, the next state is START.
- START: mul_start=1 for exactly one cycle; in_ready=0. Next state is WAIT.
- WAIT:
  - mul_A and mul_B are held stable from the START cycle until mul_done is seen (the multiplier samples them after start).
  - When mul_done=1, mul_result is captured into the 8-word buffer; next state is SEND, output index=0.
- SEND:
  - out_valid=1; out_data=buffer[index]; out_last=(index==7).
  - Data and out_last hold steady while out_ready=0.
  - On out_valid&out_ready: index increments. At index 7, next state is LOAD, counter=0, frame_cnt+1.
- Latency, nominal multiplier (done 4 cycles after start):
  - Last input word accepted at cycle t.
  - mul_start at t+1.
  - mul_done at t+5.
  - First out_valid at t+6.
- mul_done seen in LOAD, START or SEND is ignored: no capture, no state change.
- in_valid outside LOAD is ignored; in_ready=0 there.
- Consecutive frames: LOAD re-entry occurs the cycle after the last handshake. A words may arrive immediately, since mul_A/mul_B are no longer needed after done.
- mul_start is never asserted twice per frame.

Optional Feature:
- Macro MUL_HOST_TIMEOUT_EN.
- Enabled:
  - Adds parameter TIMEOUT (default 15) and output timeout_err (1 bit, reset 0).
  - A WAIT-cycle counter starts at 0 on WAIT entry.
  - If mul_done has not arrived after TIMEOUT cycles, timeout_err is set (sticky until reset), the frame is dropped and the state returns to LOAD with counter=0.
  - frame_cnt is not incremented for a dropped frame.
- Disabled: WAIT lasts indefinitely; no timeout_err port.

Test Plan:
- Reset, then feed words 0x00000001..0x00000018 with in_valid held high, multiplier model returning done 4 cycles after start -> mul_A[511:480]=0x1, mul_A[31:0]=0x10, mul_B[255:224]=0x11, mul_B[31:0]=0x18; single mul_start at t+1; first out_valid at t+6.
- Model returns result words 0xA0..0xA7 and out_ready is toggled 1,0,0,1... -> out_data sequence 0xA0..0xA7 with no skips or repeats; out_last only on 0xA7; frame_cnt=1.
- Gaps in in_valid (every other cycle) -> exactly 24 words accepted; mul_start only after the 24th; in_ready=0 from START through SEND.
- Spurious mul_done during LOAD, and a second mul_done during SEND -> ignored; buffer unchanged; no extra output.
- Assert reset in WAIT, then run a full frame -> all outputs 0 during reset; the next frame behaves as in scenario 1; frame_cnt continues from 0.
- With MUL_HOST_TIMEOUT_EN and TIMEOUT=15, the model never asserts done -> timeout_err=1 after 15 WAIT cycles; state back to LOAD (in_ready=1); frame_cnt unchanged.

Source files
------------

// File: rtl/mul_4x4_4x2_host.sv
// Host side of the 4x4-by-4x2 matrix-multiply start/done handshake: loads A/B words,
// starts the multiplier, captures the result and streams it out. Option: MUL_HOST_TIMEOUT_EN.
module mul_4x4_4x2_host #(
    parameter int unsigned DW = 32,
    parameter int unsigned NA = 16,
    parameter int unsigned NB = 8,
    parameter int unsigned NR = 8
`ifdef MUL_HOST_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             mul_start,
    output logic [NA*DW-1:0] mul_A,
    output logic [NB*DW-1:0] mul_B,
    input  logic             mul_done,
    input  logic [NR*DW-1:0] mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       frame_cnt
`ifdef MUL_HOST_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int unsigned KW = $clog2(NA + NB);
    localparam int unsigned IW = $clog2(NR);

    typedef enum logic [1:0] {StLoad, StStart, StWait, StSend} state_t;

    state_t             state;
    logic [KW-1:0]      word_cnt;
    logic [IW-1:0]      out_idx;
    logic [NR*DW-1:0]   result_buf;

`ifdef MUL_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StLoad;
            word_cnt   <= '0;
            out_idx    <= '0;
            mul_A      <= '0;
            mul_B      <= '0;
            result_buf <= '0;
            frame_cnt  <= '0;
`ifdef MUL_HOST_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                StLoad: begin
                    if (in_valid) begin
                        // Word 0 lands in the most significant slot of each bus.
                        if (word_cnt < KW'(NA)) begin
                            mul_A[(NA - 1 - int'(word_cnt)) * DW +: DW] <= in_data;
                        end else begin
                            mul_B[(NA + NB - 1 - int'(word_cnt)) * DW +: DW] <= in_data;
                        end
                        if (word_cnt == KW'(NA + NB - 1)) begin
                            word_cnt <= '0;
                            state    <= StStart;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                StStart: begin
                    state <= StWait;
`ifdef MUL_HOST_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                StWait: begin
                    if (mul_done) begin
                        result_buf <= mul_result;
                        out_idx    <= '0;
                        state      <= StSend;
`ifdef MUL_HOST_TIMEOUT_EN
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        word_cnt    <= '0;
                        state       <= StLoad;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                StSend: begin
                    if (out_ready) begin
                        if (out_idx == IW'(NR - 1)) begin
                            out_idx   <= '0;
                            word_cnt  <= '0;
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= StLoad;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

    // in_ready is masked by reset so every output reads 0 while reset is held.
    assign in_ready  = (state == StLoad) && !reset;
    assign mul_start = (state == StStart);
    assign out_valid = (state == StSend);
    assign out_last  = (state == StSend) && (out_idx == IW'(NR - 1));
    assign busy      = (state != StLoad);
    assign out_data  = result_buf[(NR - 1 - int'(out_idx)) * DW +: DW];

endmodule
